// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and frame constants for the UART TX arbiter.
// UART_TX_PARITY_EN selects the 11-bit (parity) frame; otherwise frames are 10 bits.
package uart_pkg;

   localparam int DATA_BITS         = 8;
   localparam int FRAME_BITS_PARITY = 11;
   localparam int FRAME_BITS_PLAIN  = 10;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = FRAME_BITS_PARITY;
`else
   localparam int FRAME_BITS = FRAME_BITS_PLAIN;
`endif

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_TX_PARITY_EN
      PARITY,
`endif
      STOP
   } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - bit-timed UART frame serializer (start, LSB-first data, parity, stop).
// UART_TX_PARITY_EN inserts the even-parity bit between data and stop.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load_i,
   input  logic [DATA_BITS-1:0] byte_i,
   output logic                 tx_o,
   output logic                 done_o,
   output logic                 idle_o
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   uart_state_e          state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 bit_end;
`ifdef UART_TX_PARITY_EN
   logic                 par_q, par_d;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
`ifdef UART_TX_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
      par_d   = par_q;
`endif
      tx_o    = 1'b1;
      done_o  = 1'b0;
      bit_end = (cnt_q == CNT_LAST);

      // One shared bit-period counter; it is already zero whenever IDLE is entered.
      if (state_q != IDLE) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (load_i) begin
               shift_d = byte_i;
               idx_d   = '0;
`ifdef UART_TX_PARITY_EN
               par_d   = ^byte_i;
`endif
               state_d = START;
            end
         end
         START: begin
            tx_o = 1'b0;
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            tx_o = shift_q[0];
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == IDX_LAST) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            tx_o = par_q;
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            tx_o = 1'b1;
            if (bit_end) begin
               done_o  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign idle_o = (state_q == IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter feeding N_REQ byte requesters into one UART TX line.
// UART_TX_PARITY_EN (in the serializer) selects 11-bit framing; default is 10-bit.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int N_REQ        = 4,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_REQ-1:0]           req,
   input  logic [DATA_BITS*N_REQ-1:0] data,
   output logic [N_REQ-1:0]           gnt,
   output logic [$clog2(N_REQ)-1:0]   owner,
   output logic                       busy,
   output logic                       done,
   output logic                       tx
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [N_REQ-1:0]     gnt_q, gnt_d;
   logic [IDX_W-1:0]     win, cand;
   logic                 found;
   logic                 load;
   logic                 ser_idle;
   logic [DATA_BITS-1:0] win_byte;

   // ptr_q holds the last winner, so the search starts one past it and wraps.
   always_comb begin
      win   = '0;
      cand  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   assign load     = ser_idle & found;
   assign win_byte = data[DATA_BITS*win +: DATA_BITS];

   always_comb begin
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt_d   = '0;
      if (load) begin
         ptr_d   = win;
         owner_d = win;
         gnt_d   = N_REQ'(1) << win;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q   <= IDX_W'(N_REQ - 1);
         owner_q <= '0;
         gnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt_q   <= gnt_d;
      end
   end

   uart_tx_serializer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_ser (
      .clk    (clk),
      .rst    (rst),
      .load_i (load),
      .byte_i (win_byte),
      .tx_o   (tx),
      .done_o (done),
      .idle_o (ser_idle)
   );

   assign gnt   = gnt_q;
   assign owner = owner_q;
   assign busy  = ~ser_idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed table-driven bench for uart_tx_arbiter (N_REQ=4, CLKS_PER_BIT=4).
module tb_uart_tx_arbiter;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int FC     = (PAR ? 11 : 10) * CPB;
   localparam int BUDGET = 2 * FC + 10;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] data;
   logic [3:0]  gnt;
   logic [1:0]  owner;
   logic        busy, done, tx;

   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   string tag   = "init";
   logic  g2_mon  = 1'b0;
   logic  g2_seen = 1'b0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] data;
      logic        chg_en;
      logic [31:0] chg;
      logic [3:0]  gnt;
      logic [10:0] frame;   // time order MSB first: start, d0..d7, parity, stop
   } vec_t;

   vec_t vecs [7];

   uart_tx_arbiter #(
      .N_REQ        (4),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .data  (data),
      .gnt   (gnt),
      .owner (owner),
      .busy  (busy),
      .done  (done),
      .tx    (tx)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (g2_mon && gnt[2]) g2_seen <= 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s [%s] got=%h want=%h", name, tag, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [10:0] f, input int t);
      if (PAR || t < 9) return f[10-t];
      return f[0];
   endfunction

   function automatic logic [31:0] idx_of(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return i;
      return 0;
   endfunction

   task automatic wait_gnt(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         @(posedge clk); #1;
         if (gnt != 4'b0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic wait_idle(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < BUDGET; i++) begin
         @(posedge clk); #1;
         if (!busy) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      logic ok;
      req  = v.req;
      data = v.data;
      wait_gnt(ok);
      chk("gnt_seen", ok, 1);
      if (!ok) return;
      for (int c = 0; c < FC; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         chk("gnt", gnt, (c == 0) ? v.gnt : 4'b0);
         chk("tx", tx, exp_bit(v.frame, c / CPB));
         chk("done", done, c == FC - 1);
         chk("busy", busy, 1);
         if (c == 0) begin
            chk("owner", owner, idx_of(v.gnt));
            req = 4'b0;
            if (v.chg_en) data = v.chg;
         end
      end
      @(posedge clk); #1;
      chk("busy_end", busy, 0);
      chk("done_end", done, 0);
      chk("tx_idle", tx, 1);
   endtask

   initial begin
      logic ok;
      int   prev;
      int   order [5];

      vecs[0] = '{4'b0001, 32'h0000_00A5, 1'b0, 32'h0, 4'b0001, 11'b0_10100101_0_1};
      vecs[1] = '{4'b0001, 32'h0000_0001, 1'b0, 32'h0, 4'b0001, 11'b0_10000000_1_1};
      vecs[2] = '{4'b1001, 32'h8000_00AA, 1'b0, 32'h0, 4'b1000, 11'b0_00000001_1_1};
      vecs[3] = '{4'b0011, 32'h9988_775A, 1'b0, 32'h0, 4'b0001, 11'b0_01011010_0_1};
      vecs[4] = '{4'b0011, 32'h1234_FF56, 1'b0, 32'h0, 4'b0010, 11'b0_11111111_0_1};
      vecs[5] = '{4'b0101, 32'hEE00_77CC, 1'b0, 32'h0, 4'b0100, 11'b0_00000000_0_1};
      vecs[6] = '{4'b0101, 32'h0000_003C, 1'b1, 32'h0000_00C3, 4'b0001, 11'b0_00111100_0_1};

      rst  = 1'b1;
      req  = 4'b0;
      data = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      tag = "reset";
      chk("tx", tx, 1);
      chk("gnt", gnt, 0);
      chk("done", done, 0);
      chk("busy", busy, 0);
      chk("owner", owner, 0);
      rst = 1'b0;

      for (int v = 0; v < 7; v++) begin
         tag = $sformatf("vec%0d", v);
         run_vec(vecs[v]);
      end

      // Abort a frame of 8'hFF in DATA; pointer must return to req[0]-first.
      tag  = "rst_mid";
      req  = 4'b0001;
      data = 32'h0000_00FF;
      wait_gnt(ok);
      chk("gnt_seen", ok, 1);
      req = 4'b0;
      repeat (3 * CPB + 2) @(posedge clk);
      #1;
      chk("busy_pre", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("tx", tx, 1);
      chk("busy", busy, 0);
      chk("gnt", gnt, 0);
      chk("owner", owner, 0);
      repeat (3) begin
         @(negedge clk);
         chk("done_rst", done, 0);
         chk("tx_rst", tx, 1);
      end
      @(posedge clk); #1;
      rst  = 1'b0;
      req  = 4'b1111;
      data = 32'h4433_2211;

      tag   = "rr_all";
      order = '{0, 1, 2, 3, 0};
      prev  = 0;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(ok);
         chk("gnt_seen", ok, 1);
         chk("gnt_order", gnt, 32'(1) << order[k]);
         chk("done_at_gnt", done, 0);
         if (k > 0) chk("gnt_gap", cyc - prev, FC + 1);
         prev = cyc;
      end
      req = 4'b0;
      wait_idle(ok);
      chk("idle_seen", ok, 1);

      tag     = "drop2";
      g2_mon  = 1'b1;
      req     = 4'b0110;
      data    = 32'h0077_6600;
      wait_gnt(ok);
      chk("gnt_seen", ok, 1);
      chk("gnt_first", gnt, 4'b0010);
      repeat (5) @(posedge clk);
      #1;
      req = 4'b0010;
      wait_gnt(ok);
      chk("gnt_seen2", ok, 1);
      chk("gnt_second", gnt, 4'b0010);
      req = 4'b0;
      wait_idle(ok);
      chk("idle_seen", ok, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("gnt2_never", g2_seen, 0);
      g2_mon = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, 2..8.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per serial bit, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port req, input, N_REQ bits: per-requester send request, level, held until gnt.
REQ-006 SHALL have port data, input, 8*N_REQ bits: byte i in data[8*i+7:8*i], stable while req[i] is high.
REQ-007 SHALL have port gnt, output, N_REQ bits: one-hot, one-cycle pulse; byte accepted.
REQ-008 SHALL have port owner, output, clog2(N_REQ) bits: index of the requester whose frame is in flight.
REQ-009 SHALL have port busy, output, 1 bit: high from the gnt cycle until the frame's stop bit completes.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse at the end of the stop bit.
REQ-011 SHALL have port tx, output, 1 bit: serial line, idle high.

Function
REQ-012 SHALL be built around an FSM with states IDLE, START, DATA, PARITY and STOP.
REQ-013 In IDLE with req nonzero, at the next edge the FSM SHALL:
- pick the winner round-robin, searching from (last winner + 1) mod N_REQ;
- latch that requester's byte;
- pulse gnt[winner] and drive owner to the winner;
- drive tx low and enter START.
REQ-014 START, each DATA bit, PARITY and STOP SHALL each last exactly CLKS_PER_BIT cycles, counted by a bit-period counter.
REQ-015 DATA SHALL shift 8 bits LSB first; a bit index 0..7 advances each bit period; DATA exits to PARITY after index 7.
REQ-016 PARITY SHALL drive the XOR of the 8 latched bits (even parity).
REQ-017 STOP SHALL drive tx high; at its last cycle done pulses, busy falls at the next edge, and the FSM returns to IDLE.
REQ-018 The FSM SHALL spend at least one cycle in IDLE between frames, so the minimum gap between gnt pulses is frame length + 1 cycle.
REQ-019 Requests arriving or dropping mid-frame SHALL have no effect on the current frame; a dropped req is never granted.
REQ-020 Changes to data after gnt SHALL have no effect on the current frame.
REQ-021 The round-robin pointer SHALL update only on a grant and SHALL wrap from N_REQ-1 to 0.
REQ-022 If only one requester holds req continuously, it SHALL receive every grant.

Reset
REQ-023 While rst is high, the block SHALL hold: tx=1, gnt=0, done=0, busy=0, owner=0, FSM=IDLE, counters=0.
REQ-024 After rst, the round-robin pointer SHALL be set so that req[0] has highest priority.
REQ-025 A reset mid-frame SHALL abort the frame immediately, with tx high asynchronously; no done pulse occurs.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, frames SHALL be 11 bits: start, 8 data, parity, stop.
REQ-027 With UART_TX_PARITY_EN undefined, the PARITY state SHALL be removed, DATA SHALL go directly to STOP, and frames SHALL be 10 bits.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state enum, DATA_BITS=8, and the frame-length constants for each configuration.
REQ-029 The datapath SHALL be a sub-module uart_tx_serializer that takes a load strobe and byte and outputs tx and done.
REQ-030 The arbiter and pointer logic SHALL sit in uart_tx_arbiter.

Verification (N_REQ=4, CLKS_PER_BIT=4, parity enabled unless stated)
REQ-031 Single request, req=0001, data0=8'hA5 -> gnt=0001 for 1 cycle; tx sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles; done 44 cycles after gnt.
REQ-032 All requests held, req=1111, for 5 frames -> grant order 0,1,2,3,0; consecutive gnt pulses 45 cycles apart.
REQ-033 req[2] drops before its turn while req=0110 -> grants go 1 then 1 again; gnt[2] never asserts.
REQ-034 rst asserted during the DATA state of byte 8'hFF -> tx=1 immediately, busy=0, no done; the next grant goes to req[0] first.
REQ-035 Parity disabled, single byte 8'h00 -> 10-bit frame 0,0,0,0,0,0,0,0,0,1; done 40 cycles after gnt.
REQ-036 data changed from 8'h3C to 8'hC3 the cycle after gnt -> the line carries 8'h3C with parity bit 0.
